id_exe_reg: RTL and testbench
=============================

// Module: id_exe_reg
// PURPOSE
//  EXE-stage pipeline register and valid/allowin controller, directly downstream of the ID hazard check.
//  Captures the decoded ID bundle when the ID instruction is valid and hazard-free, and inserts a bubble otherwise.
//  Drives exe_write_type/exe_wnum back to the ID hazard check and counts hazard bubbles for performance statistics.
// PARAMETERS
//  BUS_W   128  width of decoded ID->EXE bundle (operands, ALU op, imm, pc)
//  CNT_W   16   width of saturating hazard-bubble counter
// PORTS
//  clk             in   1      clock; all state updates on rising edge
//  reset           in   1      synchronous, active-high reset
//  flush           in   1      sync kill of EXE-stage contents (exception/redirect)
//  ds_valid        in   1      ID stage holds a valid instruction
//  ds_ready        in   1      ID hazard check result; 1 = no RAW hazard
//  ds_bus          in   BUS_W  decoded bundle from ID
//  ds_write_type   in   3      ID writeback type {0:wb,1:mem,2:exe}; 000 = no write
//  ds_wnum         in   5      ID destination register number
//  ds_accept       out  1      ID instruction taken this cycle; ID may advance
//  es_allowin      out  1      EXE can accept a new entry this cycle
//  es_ready_go     in   1      EXE datapath done (0 while multi-cycle op runs)
//  ms_allowin      in   1      MEM stage can accept
//  es_valid        out  1      EXE register holds a live instruction
//  es_to_ms_valid  out  1      EXE result offered to MEM
//  es_bus          out  BUS_W  registered bundle
//  exe_write_type  out  3      registered write type to hazard check; 000 when no live instruction
//  exe_wnum        out  5      registered destination number to hazard check
//  stat_clr        in   1      sync clear of bubble counter
//  bubble_cnt      out  CNT_W  saturating hazard-bubble count
// BEHAVIOUR
//  Combinational:
//   - es_allowin     = !es_valid | (es_ready_go & ms_allowin)
//   - ds_accept      = ds_valid & ds_ready & es_allowin & !flush
//   - es_to_ms_valid = es_valid & es_ready_go
//  Reset (sync, highest priority):
//   - es_valid=0, es_bus=0, exe_write_type=0, exe_wnum=0, bubble_cnt=0
//  Priority per cycle: reset > flush > load/bubble > hold.
//  Flush:
//   - es_valid<=0, exe_write_type<=0; es_bus and exe_wnum hold
//   - an ID instruction presented in the same cycle is NOT accepted (ds_accept=0)
//  es_allowin=1, no flush:
//   - ds_accept: es_valid<=1; es_bus<=ds_bus; exe_wnum<=ds_wnum
//     exe_write_type<=ds_write_type, forced to 000 when ds_wnum==0 ($0 writes never hazard)
//   - else (bubble): es_valid<=0, exe_write_type<=000; es_bus/exe_wnum hold
//  es_allowin=0: all registers hold (stall)
//  Invariant: es_valid==0 implies exe_write_type==000, so a bubble never stalls ID.
//  Latency: accepted ID bundle visible on es_bus one cycle after ds_accept.
//  Counter:
//   - bubble_cnt += 1 when ds_valid & !ds_ready & es_allowin & !flush
//   - saturates at all-ones (no wrap)
//   - stat_clr clears it to 0; if stat_clr and an increment coincide, result is 0
//  Handshake rule: an entry leaves EXE only when es_to_ms_valid & ms_allowin;
//  a new entry may enter in that same cycle (back-to-back, no bubble).
// TESTING
//  1. reset=1 for 2 cycles, then ds_valid=1, ds_ready=1, ms_allowin=1, es_ready_go=1, ds_wnum=5, ds_write_type=3'b100
//     -> next cycle es_valid=1, exe_wnum=5, exe_write_type=3'b100, es_bus=ds_bus
//  2. ds_valid=1, ds_ready=0 for 3 cycles with EXE empty
//     -> es_valid=0, exe_write_type=0 each cycle, ds_accept=0, bubble_cnt=3
//  3. es_valid=1, es_ready_go=0 for 4 cycles (divide), ds_valid=ds_ready=1
//     -> es_allowin=0, ds_accept=0, es_bus and exe_wnum unchanged; loads on the cycle es_ready_go=1
//  4. flush=1 together with ds_valid=ds_ready=1, es_allowin=1
//     -> ds_accept=0, next cycle es_valid=0, exe_write_type=0
//  5. ds_wnum=0, ds_write_type=3'b100 accepted -> es_valid=1, exe_write_type=3'b000
//  6. CNT_W=4, drive 20 bubble cycles -> bubble_cnt=15 (saturated); then stat_clr=1 -> bubble_cnt=0 next cycle

Source files
------------

// File: rtl/id_exe_reg_if.sv
// ID->EXE pipeline bundle: handshake, decoded bus, hazard feedback and stats.
interface id_exe_reg_if #(
  parameter int BUS_W = 128,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             ds_valid;
  logic             ds_ready;
  logic [BUS_W-1:0] ds_bus;
  logic [2:0]       ds_write_type;
  logic [4:0]       ds_wnum;
  logic             ds_accept;
  logic             es_allowin;
  logic             es_ready_go;
  logic             ms_allowin;
  logic             es_valid;
  logic             es_to_ms_valid;
  logic [BUS_W-1:0] es_bus;
  logic [2:0]       exe_write_type;
  logic [4:0]       exe_wnum;
  logic             stat_clr;
  logic [CNT_W-1:0] bubble_cnt;

  // Upstream/environment side: drives ID bundle, EXE progress and MEM backpressure.
  modport master (
    output flush, ds_valid, ds_ready, ds_bus, ds_write_type, ds_wnum,
           es_ready_go, ms_allowin, stat_clr,
    input  ds_accept, es_allowin, es_valid, es_to_ms_valid, es_bus,
           exe_write_type, exe_wnum, bubble_cnt
  );

  // EXE register side.
  modport slave (
    input  flush, ds_valid, ds_ready, ds_bus, ds_write_type, ds_wnum,
           es_ready_go, ms_allowin, stat_clr,
    output ds_accept, es_allowin, es_valid, es_to_ms_valid, es_bus,
           exe_write_type, exe_wnum, bubble_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// EXE-stage pipeline register with valid/allowin control, hazard feedback
// (write type / destination) and a saturating hazard-bubble counter.
module id_exe_reg #(
  parameter int BUS_W = 128,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  id_exe_reg_if.slave  pipe_io
);

  logic             es_valid_q, es_valid_d;
  logic [BUS_W-1:0] es_bus_q, es_bus_d;
  logic [2:0]       wtype_q, wtype_d;
  logic [4:0]       wnum_q, wnum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic es_allowin;
  logic ds_accept;
  logic bubble_inc;

  // Handshake: EXE frees up when empty or when its result is taken by MEM.
  always_comb begin
    es_allowin = !es_valid_q | (pipe_io.es_ready_go & pipe_io.ms_allowin);
    ds_accept  = pipe_io.ds_valid & pipe_io.ds_ready & es_allowin & !pipe_io.flush;
    bubble_inc = pipe_io.ds_valid & !pipe_io.ds_ready & es_allowin & !pipe_io.flush;
  end

  // Next state: flush beats load/bubble, which beats stall-hold; bubbles clear write type.
  always_comb begin
    es_valid_d = es_valid_q;
    es_bus_d   = es_bus_q;
    wtype_d    = wtype_q;
    wnum_d     = wnum_q;
    if (pipe_io.flush) begin
      es_valid_d = 1'b0;
      wtype_d    = 3'b000;
    end else if (es_allowin) begin
      if (ds_accept) begin
        es_valid_d = 1'b1;
        es_bus_d   = pipe_io.ds_bus;
        wnum_d     = pipe_io.ds_wnum;
        wtype_d    = (pipe_io.ds_wnum == 5'd0) ? 3'b000 : pipe_io.ds_write_type;
      end else begin
        es_valid_d = 1'b0;
        wtype_d    = 3'b000;
      end
    end
  end

  // Bubble counter: clear wins over increment, and it sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (pipe_io.stat_clr) begin
      cnt_d = '0;
    end else if (bubble_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
      wtype_q    <= 3'b000;
      wnum_q     <= 5'd0;
      cnt_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      es_bus_q   <= es_bus_d;
      wtype_q    <= wtype_d;
      wnum_q     <= wnum_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pipe_io.es_allowin     = es_allowin;
  assign pipe_io.ds_accept      = ds_accept;
  assign pipe_io.es_to_ms_valid = es_valid_q & pipe_io.es_ready_go;
  assign pipe_io.es_valid       = es_valid_q;
  assign pipe_io.es_bus         = es_bus_q;
  assign pipe_io.exe_write_type = wtype_q;
  assign pipe_io.exe_wnum       = wnum_q;
  assign pipe_io.bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized and directed bench for id_exe_reg against a behavioural model
// of a one-entry EXE stage; a CNT_W=4 twin shares the stimulus to exercise saturation.
module tb_id_exe_reg;

  localparam int BUS_W = 128;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  id_exe_reg_if #(.BUS_W(BUS_W), .CNT_W(16)) ifm ();
  id_exe_reg_if #(.BUS_W(BUS_W), .CNT_W(4))  ifs ();

  id_exe_reg #(.BUS_W(BUS_W), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .pipe_io (ifm.slave)
  );

  id_exe_reg #(.BUS_W(BUS_W), .CNT_W(4)) dutSmall (
    .clk     (clk),
    .reset   (reset),
    .pipe_io (ifs.slave)
  );

  assign ifs.flush         = ifm.flush;
  assign ifs.ds_valid      = ifm.ds_valid;
  assign ifs.ds_ready      = ifm.ds_ready;
  assign ifs.ds_bus        = ifm.ds_bus;
  assign ifs.ds_write_type = ifm.ds_write_type;
  assign ifs.ds_wnum       = ifm.ds_wnum;
  assign ifs.es_ready_go   = ifm.es_ready_go;
  assign ifs.ms_allowin    = ifm.ms_allowin;
  assign ifs.stat_clr      = ifm.stat_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the single EXE slot holds, plus an unbounded bubble tally.
  logic             mOccupied;
  logic [BUS_W-1:0] mBus;
  logic [2:0]       mWtype;
  logic [4:0]       mWnum;
  int               mBubbles;

  task automatic checkOutput(input string tag, input logic [BUS_W-1:0] observed,
                             input logic [BUS_W-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic dv,
                               input logic dr, input logic [2:0] wt, input logic [4:0] wn,
                               input logic rg, input logic ma, input logic sc,
                               input logic [BUS_W-1:0] b);
    reset             = rst;
    ifm.flush         = fl;
    ifm.ds_valid      = dv;
    ifm.ds_ready      = dr;
    ifm.ds_write_type = wt;
    ifm.ds_wnum       = wn;
    ifm.es_ready_go   = rg;
    ifm.ms_allowin    = ma;
    ifm.stat_clr      = sc;
    ifm.ds_bus        = b;
  endtask

  // One clock: drive at negedge, check everything against the model, advance the model.
  task automatic runCycle(input logic rst, input logic fl, input logic dv,
                          input logic dr, input logic [2:0] wt, input logic [4:0] wn,
                          input logic rg, input logic ma, input logic sc,
                          input logic [BUS_W-1:0] b);
    logic roomInExe;
    logic taken;
    int   sat16;
    int   sat4;
    @(negedge clk);
    applyStimulus(rst, fl, dv, dr, wt, wn, rg, ma, sc, b);
    #1;
    roomInExe = !mOccupied || (rg && ma);
    taken     = dv && dr && roomInExe && !fl;
    sat16     = (mBubbles > 65535) ? 65535 : mBubbles;
    sat4      = (mBubbles > 15) ? 15 : mBubbles;
    checkOutput("es_allowin", BUS_W'(ifm.es_allowin), BUS_W'(roomInExe));
    checkOutput("ds_accept", BUS_W'(ifm.ds_accept), BUS_W'(taken));
    checkOutput("es_to_ms_valid", BUS_W'(ifm.es_to_ms_valid), BUS_W'(mOccupied && rg));
    checkOutput("es_valid", BUS_W'(ifm.es_valid), BUS_W'(mOccupied));
    checkOutput("es_bus", ifm.es_bus, mBus);
    checkOutput("exe_write_type", BUS_W'(ifm.exe_write_type), BUS_W'(mWtype));
    checkOutput("exe_wnum", BUS_W'(ifm.exe_wnum), BUS_W'(mWnum));
    checkOutput("bubble_cnt", BUS_W'(ifm.bubble_cnt), BUS_W'(sat16));
    checkOutput("bubble_cnt4", BUS_W'(ifs.bubble_cnt), BUS_W'(sat4));
    if (rst) begin
      mOccupied = 1'b0;
      mBus      = '0;
      mWtype    = 3'b000;
      mWnum     = 5'd0;
      mBubbles  = 0;
    end else begin
      if (fl || (roomInExe && !taken)) begin
        mOccupied = 1'b0;
        mWtype    = 3'b000;
      end else if (taken) begin
        mOccupied = 1'b1;
        mBus      = b;
        mWnum     = wn;
        mWtype    = (wn == 5'd0) ? 3'b000 : wt;
      end
      if (sc) mBubbles = 0;
      else if (dv && !dr && roomInExe && !fl) mBubbles = mBubbles + 1;
    end
  endtask

  function automatic logic [BUS_W-1:0] randBus();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  logic [BUS_W-1:0] busA;
  logic [BUS_W-1:0] busB;

  initial begin
    checks    = 0;
    errors    = 0;
    mOccupied = 1'b0;
    mBus      = '0;
    mWtype    = 3'b000;
    mWnum     = 5'd0;
    mBubbles  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0, '0);

    // Reset for two cycles, then a clean load of wnum 5 / type 100.
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0, '0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0, '0);
    busA = randBus();
    runCycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 5'd5, 1'b1, 1'b1, 1'b0, busA);
    afterEdge();
    checkOutput("t1_es_valid", BUS_W'(ifm.es_valid), BUS_W'(1));
    checkOutput("t1_wnum", BUS_W'(ifm.exe_wnum), BUS_W'(5));
    checkOutput("t1_wtype", BUS_W'(ifm.exe_write_type), BUS_W'(3'b100));
    checkOutput("t1_bus", ifm.es_bus, busA);

    // Three hazard bubbles.
    for (int i = 0; i < 3; i++)
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, randBus());
    afterEdge();
    checkOutput("t2_es_valid", BUS_W'(ifm.es_valid), BUS_W'(0));
    checkOutput("t2_wtype", BUS_W'(ifm.exe_write_type), BUS_W'(0));
    checkOutput("t2_cnt", BUS_W'(ifm.bubble_cnt), BUS_W'(3));

    // Multi-cycle op stalls EXE for four cycles, then releases and loads.
    busA = randBus();
    runCycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0, busA);
    for (int i = 0; i < 4; i++)
      runCycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd12, 1'b0, 1'b1, 1'b0, randBus());
    afterEdge();
    checkOutput("t3_hold_bus", ifm.es_bus, busA);
    checkOutput("t3_hold_wnum", BUS_W'(ifm.exe_wnum), BUS_W'(9));
    busB = randBus();
    runCycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd12, 1'b1, 1'b1, 1'b0, busB);
    afterEdge();
    checkOutput("t3_load_bus", ifm.es_bus, busB);

    // Flush coinciding with a hazard-free ID instruction.
    runCycle(1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 5'd3, 1'b1, 1'b1, 1'b0, randBus());
    afterEdge();
    checkOutput("t4_es_valid", BUS_W'(ifm.es_valid), BUS_W'(0));
    checkOutput("t4_wtype", BUS_W'(ifm.exe_write_type), BUS_W'(0));

    // Writes to $0 never advertise a hazard.
    runCycle(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 5'd0, 1'b1, 1'b1, 1'b0, randBus());
    afterEdge();
    checkOutput("t5_es_valid", BUS_W'(ifm.es_valid), BUS_W'(1));
    checkOutput("t5_wtype", BUS_W'(ifm.exe_write_type), BUS_W'(0));

    // Twenty bubbles saturate the 4-bit counter; then clear it.
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b1, '0);
    for (int i = 0; i < 20; i++)
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 5'd4, 1'b1, 1'b1, 1'b0, randBus());
    afterEdge();
    checkOutput("t6_sat4", BUS_W'(ifs.bubble_cnt), BUS_W'(15));
    checkOutput("t6_cnt16", BUS_W'(ifm.bubble_cnt), BUS_W'(20));
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 5'd4, 1'b1, 1'b1, 1'b1, randBus());
    afterEdge();
    checkOutput("t6_clr4", BUS_W'(ifs.bubble_cnt), BUS_W'(0));
    checkOutput("t6_clr16", BUS_W'(ifm.bubble_cnt), BUS_W'(0));

    // Random traffic with occasional flush, clear and $0 destinations.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wn;
      wn = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      runCycle(1'b0, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
               3'($urandom), wn, ($urandom_range(0, 3) != 0), 1'($urandom),
               ($urandom_range(0, 31) == 0), randBus());
    end
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1, 1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
